// File: rtl/alu_arbiter_mips.sv
// Round-robin arbiter sharing one alu_mips between two requesters, with a valid/ready response.
// Define ALU_OPCHECK_EN to reject unsupported ALU control codes and add the rsp_err output.
module alu_arbiter_mips #(
  parameter int DATA_W = 32,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [4:0]        req_shamt0,
  input  logic [4:0]        req_shamt1,
  input  logic [3:0]        req_ctrl0,
  input  logic [3:0]        req_ctrl1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  input  logic              rsp_ready0,
  input  logic              rsp_ready1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
`ifdef ALU_OPCHECK_EN
  output logic              rsp_err,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_prio;
  logic                r_owner;
  logic [3:0]          r_cnt;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_zero;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [4:0]          r_alu_shamt;
  logic [3:0]          r_alu_control;

  logic                w_win;
  logic                w_accept;
  logic                w_sel;
  logic                w_rsp_take;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [4:0]          w_sel_shamt;
  logic [3:0]          w_sel_ctrl;

  // With both ports valid the priority port wins; otherwise the lone valid port wins.
  assign w_win       = (req_valid0 & req_valid1) ? r_prio : req_valid1;
  assign w_accept    = req_ready0 | req_ready1;
  assign w_sel       = req_ready1;
  assign w_sel_a     = w_sel ? req_a1     : req_a0;
  assign w_sel_b     = w_sel ? req_b1     : req_b0;
  assign w_sel_shamt = w_sel ? req_shamt1 : req_shamt0;
  assign w_sel_ctrl  = w_sel ? req_ctrl1  : req_ctrl0;
  assign w_rsp_take  = r_owner ? rsp_ready1 : rsp_ready0;

`ifdef ALU_OPCHECK_EN
  logic r_rsp_err;
  assign rsp_err = r_rsp_err;

  always_comb begin
    case (w_sel_ctrl)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd12: w_illegal = 1'b0;
      default:                                   w_illegal = 1'b1;
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)        w_state_next = w_illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (r_cnt == 4'd1)   w_state_next = ST_RESP;
      ST_RESP:  if (w_rsp_take)      w_state_next = ST_IDLE;
      default:                       w_state_next = ST_IDLE;
    endcase
  end

  // Ready is forced low during reset even though the state already reads IDLE.
  always_comb begin
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    if (reset_n && (r_state == ST_IDLE)) begin
      req_ready0 = req_valid0 & ~w_win;
      req_ready1 = req_valid1 &  w_win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_cnt         <= 4'd0;
      r_rsp_valid   <= 2'b00;
      r_rsp_data    <= '0;
      r_rsp_zero    <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_shamt   <= 5'd0;
      r_alu_control <= 4'd0;
`ifdef ALU_OPCHECK_EN
      r_rsp_err     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_owner <= w_sel;
        r_prio  <= ~w_sel;
        r_cnt   <= LP_SETTLE;
        if (!w_illegal) begin
          r_alu_a       <= w_sel_a;
          r_alu_b       <= w_sel_b;
          r_alu_shamt   <= w_sel_shamt;
          r_alu_control <= w_sel_ctrl;
        end else begin
          r_rsp_data         <= '0;
          r_rsp_zero         <= 1'b1;
          r_rsp_valid[w_sel] <= 1'b1;
`ifdef ALU_OPCHECK_EN
          r_rsp_err          <= 1'b1;
`endif
        end
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_rsp_data           <= alu_out;
          r_rsp_zero           <= alu_zero;
          r_rsp_valid[r_owner] <= 1'b1;
`ifdef ALU_OPCHECK_EN
          r_rsp_err            <= 1'b0;
`endif
        end
      end
      if ((r_state == ST_RESP) && w_rsp_take) r_rsp_valid <= 2'b00;
    end
  end

  assign rsp_valid0  = r_rsp_valid[0];
  assign rsp_valid1  = r_rsp_valid[1];
  assign rsp_data    = r_rsp_data;
  assign rsp_zero    = r_rsp_zero;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_shamt   = r_alu_shamt;
  assign alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_arbiter_mips.sv
// Bench for alu_arbiter_mips: behavioural ALU, transaction-level arbiter model and response scoreboard.
module tb_alu_arbiter_mips;
  localparam int DW     = 32;
  localparam int SETTLE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          v   [2];
  logic [DW-1:0] ra  [2];
  logic [DW-1:0] rb  [2];
  logic [4:0]    rsh [2];
  logic [3:0]    rc  [2];
  logic          rr  [2];

  logic          req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero, alu_zero;
  logic [DW-1:0] rsp_data, alu_a, alu_b, alu_out;
  logic [4:0]    alu_shamt;
  logic [3:0]    alu_control;
`ifdef ALU_OPCHECK_EN
  logic          rsp_err;
`endif

  // MIPS ALU behaviour: undefined codes give 0.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [4:0] sh, input logic [3:0] c);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return b << sh;
      4'd4:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? DW'(1) : '0;
      4'd12:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic bit legal_code(input logic [3:0] c);
    return (c == 0) || (c == 1) || (c == 2) || (c == 4) || (c == 6) || (c == 7) || (c == 12);
  endfunction

  assign alu_out  = alu_fn(alu_a, alu_b, alu_shamt, alu_control);
  assign alu_zero = (alu_out == '0);

  alu_arbiter_mips #(.DATA_W(DW), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid0(v[0]), .req_valid1(v[1]),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(ra[0]), .req_b0(rb[0]), .req_a1(ra[1]), .req_b1(rb[1]),
    .req_shamt0(rsh[0]), .req_shamt1(rsh[1]),
    .req_ctrl0(rc[0]), .req_ctrl1(rc[1]),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rr[0]), .rsp_ready1(rr[1]),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
`ifdef ALU_OPCHECK_EN
    .rsp_err(rsp_err),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] d;
    logic          z;
    logic          e;
  } exp_t;

  exp_t          sb_q[$];
  bit            m_flight, m_rsp, m_done, m_prio, m_owner;
  int            m_wait;
  logic [DW-1:0] last_d;
  logic          last_z, last_e;
  bit            acc_flag [2];
  bit            e0, e1;
  int            ops_done = 0;
  bit            wd_en = 0;

  // Model of the shared-ALU service: who may be granted now, when the answer must appear, what it holds.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs", {req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero, rsp_data,
                              alu_a, alu_b, alu_shamt, alu_control}, '0);
      m_flight = 0; m_rsp = 0; m_done = 0; m_prio = 0; m_owner = 0; m_wait = 0;
      sb_q.delete();
      last_d = '0; last_z = 1'b0; last_e = 1'b0;
      acc_flag[0] = 0; acc_flag[1] = 0;
    end else begin
      if (m_done) begin
        last_d = sb_q[0].d; last_z = sb_q[0].z; last_e = sb_q[0].e;
        void'(sb_q.pop_front());
        m_flight = 0; m_rsp = 0; m_done = 0;
      end else if (m_flight && !m_rsp) begin
        m_wait--;
        if (m_wait == 0) m_rsp = 1;
      end

      check("rsp_valid0", rsp_valid0, m_rsp && !m_owner);
      check("rsp_valid1", rsp_valid1, m_rsp && m_owner);
      if (m_rsp && sb_q.size() > 0) begin
        check("rsp_data", rsp_data, sb_q[0].d);
        check("rsp_zero", rsp_zero, sb_q[0].z);
`ifdef ALU_OPCHECK_EN
        check("rsp_err", rsp_err, sb_q[0].e);
`endif
        if (m_owner ? rr[1] : rr[0]) begin
          m_done = 1;
          ops_done++;
          $display("op %0d: port=%0d data=%h zero=%0d", ops_done, m_owner, rsp_data, rsp_zero);
        end
      end else begin
        check("rsp_data_hold", rsp_data, last_d);
        check("rsp_zero_hold", rsp_zero, last_z);
`ifdef ALU_OPCHECK_EN
        check("rsp_err_hold", rsp_err, last_e);
`endif
      end

      e0 = !m_flight && v[0] && (!v[1] || !m_prio);
      e1 = !m_flight && v[1] && (!v[0] ||  m_prio);
      check("req_ready0", req_ready0, e0);
      check("req_ready1", req_ready1, e1);
      acc_flag[0] = e0;
      acc_flag[1] = e1;
      if (e0 || e1) begin
        exp_t x;
        int   p;
        p      = e1 ? 1 : 0;
        x.port = e1;
        x.d    = alu_fn(ra[p], rb[p], rsh[p], rc[p]);
        x.z    = (x.d == '0);
        x.e    = 1'b0;
        m_wait = SETTLE + 1;
`ifdef ALU_OPCHECK_EN
        if (!legal_code(rc[p])) begin
          x.d = '0; x.z = 1'b1; x.e = 1'b1; m_wait = 1;
        end
`endif
        sb_q.push_back(x);
        m_flight = 1; m_rsp = 0; m_owner = e1; m_prio = !e1;
      end
    end
  end

  task automatic new_req(input int p);
    logic [3:0] codes [9];
    codes = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd12, 4'd9, 4'd3};
    ra[p]  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
    rb[p]  = ($urandom_range(0, 3) == 0) ? ra[p] : DW'($urandom);
    rsh[p] = 5'($urandom_range(0, 31));
    rc[p]  = codes[$urandom_range(0, 8)];
    v[p]   = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] sh, input logic [3:0] c);
    ra[p] = a; rb[p] = b; rsh[p] = sh; rc[p] = c; v[p] = 1'b1;
  endtask

  // One clock per iteration; percentages choose new requests and response readiness.
  task automatic run(input int n, input int p0, input int p1, input int r0, input int r1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int x = 0; x < 2; x++) begin
        if (v[x] && acc_flag[x]) v[x] = 1'b0;
        if (v[x] && wd_en && $urandom_range(0, 99) < 2) v[x] = 1'b0;
        if (!v[x] && $urandom_range(0, 99) < ((x == 0) ? p0 : p1)) new_req(x);
      end
      rr[0] = ($urandom_range(0, 99) < r0);
      rr[1] = ($urandom_range(0, 99) < r1);
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    #1;
    check("async_reset", {req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_zero, rsp_data,
                          alu_a, alu_b, alu_shamt, alu_control}, '0);
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    for (int x = 0; x < 2; x++) begin
      v[x] = 1'b0; ra[x] = '0; rb[x] = '0; rsh[x] = '0; rc[x] = '0; rr[x] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    set_req(0, 32'd5, 32'd3, 5'd0, 4'd4);
    run(8, 0, 0, 100, 100);

    pulse_reset(2);
    set_req(0, 32'd7, 32'd7, 5'd0, 4'd6);
    set_req(1, 32'hF0, 32'h0F, 5'd0, 4'd1);
    run(14, 0, 0, 100, 100);

    run(30, 100, 100, 100, 100);
    run(20, 0, 0, 100, 100);

    set_req(0, 32'h1234, 32'h1, 5'd0, 4'd4);
    run(2, 0, 0, 0, 100);
    set_req(1, 32'h10, 32'h20, 5'd0, 4'd4);
    run(SETTLE + 6, 0, 0, 0, 100);
    run(12, 0, 0, 100, 100);

    set_req(1, 32'd0, 32'd1, 5'd4, 4'd2);
    run(10, 0, 0, 100, 100);

    set_req(0, 32'd6, 32'd3, 5'd0, 4'd9);
    run(10, 0, 0, 100, 100);

    set_req(0, 32'd9, 32'd9, 5'd0, 4'd4);
    run(1, 0, 0, 100, 100);
    pulse_reset(2);
    run(6, 0, 0, 100, 100);
    set_req(0, 32'd1, 32'd2, 5'd0, 4'd4);
    set_req(1, 32'd3, 32'd4, 5'd0, 4'd6);
    run(14, 0, 0, 100, 100);

    wd_en = 1;
    for (int blk = 0; blk < 15; blk++) begin
      run(100, $urandom_range(0, 100), $urandom_range(0, 100),
          $urandom_range(10, 100), $urandom_range(10, 100));
    end
    wd_en = 0;

    guard = 0;
    while ((v[0] || v[1] || m_flight) && guard < 300) begin
      run(1, 0, 0, 100, 100);
      guard++;
    end
    check("drain_timeout", guard >= 300, 1'b0);
    run(3, 0, 0, 100, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
